// File: rtl/neighbor_link_ctx_pkg.sv
// Shared decoder parameters: stage codes, stage-field width and link
// boundary-condition encodings used by the link context blocks.
package neighbor_link_ctx_pkg;

    localparam int STAGE_WIDTH = 4;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                  = 4'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_SPREADING_BOUNDARY    = 4'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                  = 4'd2;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE                 = 4'd3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING               = 4'd4;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_PREPARING = 4'd5;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING   = 4'd6;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING    = 4'd7;
    localparam logic [STAGE_WIDTH-1:0] STAGE_ERASURE_LOADING       = 4'd8;
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID          = 4'd9;

    localparam logic [1:0] BC_NORMAL   = 2'd0;
    localparam logic [1:0] BC_BOUNDARY = 2'd1;
    localparam logic [1:0] BC_ABSENT   = 2'd2;
    localparam logic [1:0] BC_RESERVED = 2'd3;

    // Loading stages only touch parameters; every other stage runs the
    // growth / error update.
    function automatic logic is_update_stage(input logic [STAGE_WIDTH-1:0] stage);
        return !((stage == STAGE_PARAMETERS_LOADING) ||
                 (stage == STAGE_ERASURE_LOADING)    ||
                 (stage == STAGE_MEASUREMENT_LOADING));
    endfunction

    // Reserved encoding behaves exactly like an absent link.
    function automatic logic is_absent(input logic [1:0] bc);
        return bc[1];
    endfunction

endpackage

// File: rtl/neighbor_link_ctx_entry.sv
// One decoding context of a link: growth, weight, boundary condition,
// erasure and error registers plus their next-state logic. Only updates
// when its write enable (context selected) is high.
module link_ctx_entry
    import neighbor_link_ctx_pkg::*;
#(
    parameter int MAX_WEIGHT     = 2,
    parameter int LINK_BIT_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      we_i,
    input  logic [STAGE_WIDTH-1:0]    global_stage_i,
    input  logic                      a_increase_i,
    input  logic                      b_increase_i,
    input  logic                      a_is_error_i,
    input  logic                      b_is_error_i,
    input  logic                      is_error_systolic_i,
    input  logic [LINK_BIT_WIDTH-1:0] weight_i,
    input  logic [1:0]                bc_i,
    input  logic                      erased_i,
    output logic [LINK_BIT_WIDTH-1:0] growth_o,
    output logic [LINK_BIT_WIDTH-1:0] growth_d_o,
    output logic [LINK_BIT_WIDTH-1:0] weight_o,
    output logic [1:0]                bc_o,
    output logic                      erased_o,
    output logic                      is_error_o
);

    // Wide enough for growth (<= MAX_WEIGHT) plus two increments: no wrap.
    localparam int SUM_WIDTH = $clog2(MAX_WEIGHT + 3);
    localparam logic [LINK_BIT_WIDTH-1:0] MAX_W = LINK_BIT_WIDTH'(MAX_WEIGHT);

    logic [LINK_BIT_WIDTH-1:0] growth_q, growth_d;
    logic [LINK_BIT_WIDTH-1:0] weight_q, weight_d;
    logic [1:0]                bc_q, bc_d;
    logic                      erased_q, erased_d;
    logic                      is_error_q, is_error_d;
    logic [SUM_WIDTH-1:0]      sum;
    logic [SUM_WIDTH-1:0]      weight_ext;

    // Next-state for this context; everything holds unless selected.
    always_comb begin
        growth_d   = growth_q;
        weight_d   = weight_q;
        bc_d       = bc_q;
        erased_d   = erased_q;
        is_error_d = is_error_q;
        sum        = SUM_WIDTH'(growth_q);
        weight_ext = SUM_WIDTH'(weight_q);
        if (we_i) begin
            case (global_stage_i)
                STAGE_PARAMETERS_LOADING: begin
                    // Out-of-range weights clamp so the growth sum cannot overflow.
                    weight_d = (weight_i > MAX_W) ? MAX_W : weight_i;
                    bc_d     = bc_i;
                end
                STAGE_ERASURE_LOADING: begin
                    erased_d = erased_i;
                end
                STAGE_MEASUREMENT_LOADING: begin
                    growth_d   = '0;
                    is_error_d = 1'b0;
                end
                default: begin
                    if (bc_q == BC_NORMAL) begin
                        sum = SUM_WIDTH'(growth_q) + SUM_WIDTH'(a_increase_i)
                            + SUM_WIDTH'(b_increase_i);
                    end else if (bc_q == BC_BOUNDARY) begin
                        sum = SUM_WIDTH'(growth_q) + SUM_WIDTH'(a_increase_i);
                    end
                    if (is_absent(bc_q)) begin
                        growth_d = '0;
                    end else if (sum > weight_ext) begin
                        growth_d = weight_q;
                    end else begin
                        growth_d = sum[LINK_BIT_WIDTH-1:0];
                    end
                    // An erased edge is free: it is grown immediately.
                    if (erased_i) begin
                        growth_d = weight_q;
                    end

                    if (is_absent(bc_q)) begin
                        is_error_d = 1'b0;
                    end else if (global_stage_i == STAGE_RESULT_VALID) begin
                        is_error_d = is_error_systolic_i;
                    end else if (bc_q == BC_NORMAL) begin
                        is_error_d = a_is_error_i | b_is_error_i;
                    end else begin
                        is_error_d = a_is_error_i;
                    end
                end
            endcase
        end
    end

    // Context state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            growth_q   <= '0;
            weight_q   <= '0;
            bc_q       <= BC_NORMAL;
            erased_q   <= 1'b0;
            is_error_q <= 1'b0;
        end else begin
            growth_q   <= growth_d;
            weight_q   <= weight_d;
            bc_q       <= bc_d;
            erased_q   <= erased_d;
            is_error_q <= is_error_d;
        end
    end

    assign growth_o   = growth_q;
    assign growth_d_o = growth_d;
    assign weight_o   = weight_q;
    assign bc_o       = bc_q;
    assign erased_o   = erased_q;
    assign is_error_o = is_error_q;

endmodule

// File: rtl/neighbor_link_ctx.sv
// Multi-context decoder link: NUM_CONTEXTS independent link states, one of
// which is selected per cycle for update and combinational readout.
module neighbor_link_ctx
    import neighbor_link_ctx_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 6,
    parameter int MAX_WEIGHT = 2,
    parameter int NUM_CONTEXTS = 4,
    localparam int CTX_WIDTH = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1,
    localparam int LINK_BIT_WIDTH = $clog2(MAX_WEIGHT + 1),
    localparam int EXPOSED_DATA_SIZE = ADDRESS_WIDTH + 7
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [STAGE_WIDTH-1:0]       global_stage,
    input  logic [CTX_WIDTH-1:0]         context_id,
    input  logic                         a_increase,
    input  logic                         b_increase,
    input  logic                         a_is_error_in,
    input  logic                         b_is_error_in,
    input  logic                         is_error_systolic_in,
    input  logic [LINK_BIT_WIDTH-1:0]    weight_in,
    input  logic [1:0]                   boundary_condition_in,
    input  logic                         erased,
    input  logic [EXPOSED_DATA_SIZE-1:0] a_input_data,
    input  logic [EXPOSED_DATA_SIZE-1:0] b_input_data,
    output logic [EXPOSED_DATA_SIZE-1:0] a_output_data,
    output logic [EXPOSED_DATA_SIZE-1:0] b_output_data,
    output logic                         fully_grown,
    output logic                         is_boundary,
    output logic                         is_error,
    output logic                         erased_out,
    output logic                         just_grown,
    output logic [LINK_BIT_WIDTH-1:0]    weight_out,
    output logic [1:0]                   boundary_condition_out
);

    logic [LINK_BIT_WIDTH-1:0] growth_arr   [NUM_CONTEXTS];
    logic [LINK_BIT_WIDTH-1:0] growth_d_arr [NUM_CONTEXTS];
    logic [LINK_BIT_WIDTH-1:0] weight_arr   [NUM_CONTEXTS];
    logic [1:0]                bc_arr       [NUM_CONTEXTS];
    logic                      erased_arr   [NUM_CONTEXTS];
    logic                      error_arr    [NUM_CONTEXTS];

    logic                      sel_valid;
    logic [LINK_BIT_WIDTH-1:0] sel_growth, sel_growth_d, sel_weight;
    logic [1:0]                sel_bc;
    logic                      sel_erased, sel_error;
    logic                      just_grown_q, just_grown_d;

    for (genvar gi = 0; gi < NUM_CONTEXTS; gi++) begin : g_ctx
        link_ctx_entry #(
            .MAX_WEIGHT     (MAX_WEIGHT),
            .LINK_BIT_WIDTH (LINK_BIT_WIDTH)
        ) u_entry (
            .clk                 (clk),
            .reset_n             (reset_n),
            .we_i                (context_id == CTX_WIDTH'(gi)),
            .global_stage_i      (global_stage),
            .a_increase_i        (a_increase),
            .b_increase_i        (b_increase),
            .a_is_error_i        (a_is_error_in),
            .b_is_error_i        (b_is_error_in),
            .is_error_systolic_i (is_error_systolic_in),
            .weight_i            (weight_in),
            .bc_i                (boundary_condition_in),
            .erased_i            (erased),
            .growth_o            (growth_arr[gi]),
            .growth_d_o          (growth_d_arr[gi]),
            .weight_o            (weight_arr[gi]),
            .bc_o                (bc_arr[gi]),
            .erased_o            (erased_arr[gi]),
            .is_error_o          (error_arr[gi])
        );
    end

    // Select the addressed context; an unmapped id reads as all zeros.
    always_comb begin
        sel_valid    = 1'b0;
        sel_growth   = '0;
        sel_growth_d = '0;
        sel_weight   = '0;
        sel_bc       = '0;
        sel_erased   = 1'b0;
        sel_error    = 1'b0;
        for (int i = 0; i < NUM_CONTEXTS; i++) begin
            if (context_id == CTX_WIDTH'(i)) begin
                sel_valid    = 1'b1;
                sel_growth   = growth_arr[i];
                sel_growth_d = growth_d_arr[i];
                sel_weight   = weight_arr[i];
                sel_bc       = bc_arr[i];
                sel_erased   = erased_arr[i];
                sel_error    = error_arr[i];
            end
        end
    end

    // Pulse only on a growth update crossing into fully grown; loads,
    // clears and plain context switches cannot produce this transition.
    always_comb begin
        just_grown_d = sel_valid && is_update_stage(global_stage)
                    && (sel_growth < sel_weight)
                    && (sel_growth_d >= sel_weight);
    end

    // just_grown pulse register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            just_grown_q <= 1'b0;
        end else begin
            just_grown_q <= just_grown_d;
        end
    end

    assign fully_grown            = sel_valid && (sel_growth >= sel_weight);
    assign is_boundary            = fully_grown && (sel_bc == BC_BOUNDARY);
    assign is_error               = sel_error;
    assign erased_out             = sel_erased;
    assign weight_out             = sel_weight;
    assign boundary_condition_out = sel_bc;
    assign just_grown             = just_grown_q;
    assign a_output_data = (sel_valid && sel_bc == BC_NORMAL) ? b_input_data : '0;
    assign b_output_data = (sel_valid && sel_bc == BC_NORMAL) ? a_input_data : '0;

endmodule

// File: doc/neighbor_link_ctx.md
NEIGHBOR_LINK_CTX -- requirements
Module: neighbor_link_ctx

Interface
REQ-001 SHALL have parameters, one per line:
  ADDRESS_WIDTH, 6, node address width in exposed data
  MAX_WEIGHT, 2, largest loadable edge weight
  NUM_CONTEXTS, 4, independent decoding contexts held per link (>=1)
REQ-002 SHALL derive CTX_WIDTH = max(1, clog2(NUM_CONTEXTS)), LINK_BIT_WIDTH = clog2(MAX_WEIGHT+1), and EXPOSED_DATA_SIZE = ADDRESS_WIDTH+7.
REQ-003 SHALL have ports, one per line (name direction width meaning):
  clk  in  1  single clock
  reset_n  in  1  asynchronous, active-low reset
  global_stage  in  STAGE_WIDTH  decoder stage
  context_id  in  CTX_WIDTH  context selected this cycle
  a_increase, b_increase  in  1 each  growth request from endpoint A/B
  a_is_error_in, b_is_error_in  in  1 each  error claim from A/B
  is_error_systolic_in  in  1  result-readout chain input
  weight_in  in  LINK_BIT_WIDTH  weight for load
  boundary_condition_in  in  2  0 normal, 1 boundary, 2 absent, 3 reserved (treated as 2)
  erased  in  1  erasure flag for load/grow
  a_input_data, b_input_data  in  EXPOSED_DATA_SIZE  endpoint data
  a_output_data, b_output_data  out  EXPOSED_DATA_SIZE  crossed data
  fully_grown, is_boundary, is_error, erased_out  out  1 each  selected-context state
  just_grown  out  1  one-cycle pulse: selected context became fully grown
  weight_out  out  LINK_BIT_WIDTH; boundary_condition_out  out  2  selected-context parameters

Function
REQ-004 SHALL hold per context: growth, weight, boundary_condition, erased, is_error; every stage action SHALL read/write only entry [context_id]; other entries SHALL hold.
REQ-005 All outputs SHALL be combinational views of entry [context_id]; switching context_id SHALL change outputs the same cycle with no penalty.
REQ-006 STAGE_PARAMETERS_LOADING: weight and boundary_condition of entry SHALL load from inputs at clock edge.
REQ-007 STAGE_ERASURE_LOADING: erased of entry SHALL load from erased.
REQ-008 STAGE_MEASUREMENT_LOADING: growth and is_error of entry SHALL clear to 0.
REQ-009 Other stages: growth_next = min(growth + a_inc + b_inc, weight) for bc 0; min(growth + a_inc, weight) for bc 1; 0 for bc 2/3; if erased input is 1, growth_next = weight. Intermediate sum SHALL be clog2(MAX_WEIGHT+3) bits, no wrap.
REQ-010 is_error next: bc 0 -> a_is_error_in|b_is_error_in; bc 1 -> a_is_error_in; STAGE_RESULT_VALID with bc 0/1 -> is_error_systolic_in; bc 2/3 -> 0 always.
REQ-011 fully_grown = (growth >= weight); weight 0 SHALL read fully grown; is_boundary = fully_grown && bc==1.
REQ-012 just_grown SHALL be a registered pulse, high for exactly one cycle after the update that moves entry [context_id] from growth<weight to growth>=weight; it SHALL NOT fire on parameter load, measurement clear, or a context switch alone.
REQ-013 a_output_data = b_input_data and b_output_data = a_input_data when bc==0, else 0.
REQ-014 context_id >= NUM_CONTEXTS SHALL write nothing and outputs SHALL read 0.

Reset
REQ-015 reset_n low SHALL asynchronously clear every entry field and just_grown to 0; all outputs therefore read 0 except fully_grown=1 (weight 0).
REQ-016 Reset asserted mid-growth SHALL discard all context state; first post-release edge behaves as from reset.

Structure
REQ-017 Stage codes, STAGE_WIDTH and boundary-condition encodings SHALL come from the shared parameters package; no local redefinition.
REQ-018 One sub-module, link_ctx_entry (one context's registers and update logic), SHALL be instantiated NUM_CONTEXTS times; top holds mux and just_grown logic.

Verification
REQ-019 Load ctx0 w=2 bc0, ctx1 w=2 bc1; grow ctx0 a=b=1 one cycle -> ctx0 growth 2, fully_grown=1, just_grown pulse; ctx1 untouched.
REQ-020 ctx1 bc1 w=2, b_increase=1 for 3 cycles -> growth stays 0; then a_increase=1 two cycles -> is_boundary=1.
REQ-021 w=2 growth 1, a=b=1 -> growth saturates at 2, never wraps; further requests -> just_grown stays 0.
REQ-022 Erasure load ctx2 erased=1 then grow stage -> growth=weight next edge, erased_out=1; ctx3 with erased=0 unaffected.
REQ-023 Alternate context_id 0/1 each cycle during growth -> each context accumulates only its own cycles; RESULT_VALID with systolic_in=1 sets is_error only for selected bc0/1 contexts.
REQ-024 Assert reset_n low mid-growth between edges -> outputs 0 immediately (fully_grown=1), all contexts cleared after release.
